// File: rtl/sram_bus_arbiter.sv
// Two-to-one arbiter sharing one SRAM-style memory port between the instruction
// fetch and data access requesters, with alternating priority on ties.
module sram_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [1:0]            inst_size,
    input  logic [DATA_W/8-1:0]   inst_wstrb,
    input  logic [ADDR_W-1:0]     inst_addr,
    input  logic [DATA_W-1:0]     inst_wdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,

    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,

    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // Handshake: a request is taken when req and addr_ok are both high in the
    // same cycle; the requester holds req and its fields until then. data_ok
    // marks the single cycle in which the response (or write ack) is valid.

    logic [1:0]          state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic in_idle;
    logic grant_inst;
    logic grant_data;
    logic rsp_fire;

    assign in_idle = (state_q == S_IDLE);

    // On a tie the requester that did not win last time goes first.
    assign grant_inst = in_idle & inst_req & (~data_req | last_grant_q);
    assign grant_data = in_idle & data_req & (~inst_req | ~last_grant_q);

    assign rsp_fire = (state_q == S_WAIT) & mem_data_ok;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = rsp_fire & ~owner_q;
    assign data_data_ok = rsp_fire & owner_q;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req   = (state_q == S_REQ);
    assign mem_wr    = wr_q;
    assign mem_size  = size_q;
    assign mem_wstrb = wstrb_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign dbg_state_o = state_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    state_d      = S_REQ;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    wr_d         = data_wr;
                    size_d       = data_size;
                    wstrb_d      = data_wstrb;
                    addr_d       = data_addr;
                    wdata_d      = data_wdata;
                end else if (grant_inst) begin
                    state_d      = S_REQ;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    wr_d         = inst_wr;
                    size_d       = inst_size;
                    wstrb_d      = inst_wstrb;
                    addr_d       = inst_addr;
                    wdata_d      = inst_wdata;
                end
            end
            S_REQ: begin
                if (mem_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            wstrb_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: the memory side is driven by hand in
// each scenario task and every output is compared against hand-computed values.
module tb_sram_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int passed = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled #1 later, well away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #2;
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0)
            $display("FAIL reset_outputs got %b exp 00000",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        else passed++;
        checks++;
        if ({dbg_state, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== 73'h0)
            $display("FAIL reset_latch got state=%0d addr=%h wdata=%h exp all zero",
                     dbg_state, mem_addr, mem_wdata);
        else passed++;
        cyc();
        reset = 0;
    endtask

    task automatic test_single_inst();
        cyc();
        inst_req = 1; inst_addr = 32'h1c000000; inst_wr = 0; inst_size = 2'd2;
        #1;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10)
            $display("FAIL single_c0_addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok});
        else passed++;
        cyc();
        inst_req = 0; inst_addr = 32'h0; mem_addr_ok = 1;
        #1;
        checks++;
        if ({mem_req, mem_addr, mem_wr} !== {1'b1, 32'h1c000000, 1'b0})
            $display("FAIL single_c1_mem got req=%b addr=%h wr=%b exp 1 1c000000 0",
                     mem_req, mem_addr, mem_wr);
        else passed++;
        checks++;
        if (inst_addr_ok !== 1'b0)
            $display("FAIL single_c1_no_addr_ok got %b exp 0", inst_addr_ok);
        else passed++;
        cyc();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h02800401;
        #1;
        checks++;
        if ({inst_data_ok, inst_rdata, data_data_ok, mem_req} !== {1'b1, 32'h02800401, 1'b0, 1'b0})
            $display("FAIL single_c2_rsp got inst_ok=%b rdata=%h data_ok=%b mem_req=%b exp 1 02800401 0 0",
                     inst_data_ok, inst_rdata, data_data_ok, mem_req);
        else passed++;
        cyc();
        mem_data_ok = 0;
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok, dbg_state} !== {1'b0, 1'b0, S_IDLE})
            $display("FAIL single_c3_idle got ok=%b%b state=%0d exp 00 0",
                     inst_data_ok, data_data_ok, dbg_state);
        else passed++;
    endtask

    task automatic test_tie();
        logic        exp_d;
        logic [31:0] exp_a;
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_0100;
        data_req = 1; data_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            exp_d = (i % 2 == 0);
            exp_a = exp_d ? 32'h0000_0200 : 32'h0000_0100;
            #1;
            checks++;
            if ({data_addr_ok, inst_addr_ok} !== {exp_d, ~exp_d})
                $display("FAIL tie_grant_%0d got data/inst=%b%b exp %b%b",
                         i, data_addr_ok, inst_addr_ok, exp_d, ~exp_d);
            else passed++;
            cyc();
            mem_addr_ok = 1;
            #1;
            checks++;
            if ({mem_req, mem_addr, data_addr_ok, inst_addr_ok} !== {1'b1, exp_a, 2'b00})
                $display("FAIL tie_mem_%0d got req=%b addr=%h ok=%b%b exp 1 %h 00",
                         i, mem_req, mem_addr, data_addr_ok, inst_addr_ok, exp_a);
            else passed++;
            cyc();
            mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hA5A5_0000 + i;
            #1;
            checks++;
            if ({data_data_ok, inst_data_ok} !== {exp_d, ~exp_d})
                $display("FAIL tie_rsp_%0d got data/inst=%b%b exp %b%b",
                         i, data_data_ok, inst_data_ok, exp_d, ~exp_d);
            else passed++;
            cyc();
            mem_data_ok = 0;
        end
        inst_req = 0; data_req = 0;
    endtask

    task automatic test_write_stall();
        logic [71:0] exp_bus;
        exp_bus = {1'b1, 1'b1, 2'd2, 4'hF, 32'h1c800010, 32'hdeadbeef};
        cyc();
        data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 32'h1c800010; data_wdata = 32'hdeadbeef;
        #1;
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
            $display("FAIL wr_accept got data/inst=%b%b exp 10", data_addr_ok, inst_addr_ok);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            cyc();
            // Scramble the upstream fields to show the memory side uses the latch.
            data_req = 0; data_wr = 0; data_wstrb = 4'h1; data_size = 2'd0;
            data_addr = 32'h1111_2222 + i; data_wdata = 32'h0;
            mem_addr_ok = (i == 4);
            #1;
            checks++;
            if ({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== exp_bus)
                $display("FAIL wr_stall_%0d got req=%b wr=%b size=%0d strb=%h addr=%h wdata=%h exp 1 1 2 f 1c800010 deadbeef",
                         i, mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
            else passed++;
        end
        cyc();
        mem_addr_ok = 0;
        #1;
        checks++;
        if ({mem_req, data_data_ok, dbg_state} !== {1'b0, 1'b0, S_WAIT})
            $display("FAIL wr_wait got req=%b data_ok=%b state=%0d exp 0 0 2",
                     mem_req, data_data_ok, dbg_state);
        else passed++;
        cyc();
        mem_data_ok = 1;
        #1;
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10)
            $display("FAIL wr_ack got data/inst=%b%b exp 10", data_data_ok, inst_data_ok);
        else passed++;
        cyc();
        mem_data_ok = 0;
        #1;
        checks++;
        if ({data_data_ok, dbg_state} !== {1'b0, S_IDLE})
            $display("FAIL wr_ack_once got data_ok=%b state=%0d exp 0 0", data_data_ok, dbg_state);
        else passed++;
    endtask

    task automatic test_spurious();
        cyc();
        mem_data_ok = 1;
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok, dbg_state} !== {2'b00, S_IDLE})
            $display("FAIL spur_idle got ok=%b%b state=%0d exp 00 0",
                     inst_data_ok, data_data_ok, dbg_state);
        else passed++;
        cyc();
        inst_req = 1; inst_addr = 32'h0000_0040;
        #1;
        checks++;
        if ({dbg_state, inst_addr_ok, inst_data_ok} !== {S_IDLE, 1'b1, 1'b0})
            $display("FAIL spur_idle_grant got state=%0d addr_ok=%b data_ok=%b exp 0 1 0",
                     dbg_state, inst_addr_ok, inst_data_ok);
        else passed++;
        cyc();
        inst_req = 0;
        #1;
        checks++;
        if ({mem_req, inst_data_ok, data_data_ok} !== 3'b100)
            $display("FAIL spur_req got req=%b ok=%b%b exp 1 00", mem_req, inst_data_ok, data_data_ok);
        else passed++;
        cyc();
        #1;
        checks++;
        if ({dbg_state, mem_req, mem_addr} !== {S_REQ, 1'b1, 32'h0000_0040})
            $display("FAIL spur_req_hold got state=%0d req=%b addr=%h exp 1 1 00000040",
                     dbg_state, mem_req, mem_addr);
        else passed++;
        mem_data_ok = 0; mem_addr_ok = 1;
        cyc();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
        #1;
        checks++;
        if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h1234_5678})
            $display("FAIL spur_complete got ok=%b rdata=%h exp 1 12345678", inst_data_ok, inst_rdata);
        else passed++;
        cyc();
        mem_data_ok = 0;
    endtask

    task automatic test_reset_in_wait();
        cyc();
        inst_req = 1; inst_addr = 32'h0000_0080;
        cyc();
        inst_req = 0; mem_addr_ok = 1;
        cyc();
        mem_addr_ok = 0;
        #1;
        checks++;
        if (dbg_state !== S_WAIT)
            $display("FAIL rst_pre_wait got state=%0d exp 2", dbg_state);
        else passed++;
        reset = 1; mem_data_ok = 1;
        #1;
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, dbg_state} !== {5'b0, S_IDLE})
            $display("FAIL rst_async got req/ok=%b state=%0d exp 00000 0",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, dbg_state);
        else passed++;
        cyc();
        reset = 0;
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok, dbg_state} !== {2'b00, S_IDLE})
            $display("FAIL rst_late_rsp got ok=%b%b state=%0d exp 00 0",
                     inst_data_ok, data_data_ok, dbg_state);
        else passed++;
        cyc();
        mem_data_ok = 0; inst_req = 1; inst_addr = 32'h0000_00c0;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1)
            $display("FAIL rst_regrant got %b exp 1", inst_addr_ok);
        else passed++;
        cyc();
        inst_req = 0; mem_addr_ok = 1;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_00c0})
            $display("FAIL rst_regrant_mem got req=%b addr=%h exp 1 000000c0", mem_req, mem_addr);
        else passed++;
        cyc();
        mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        checks++;
        if (inst_data_ok !== 1'b1)
            $display("FAIL rst_regrant_rsp got %b exp 1", inst_data_ok);
        else passed++;
        cyc();
        mem_data_ok = 0;
    endtask

    task automatic test_inst_during_wait();
        cyc();
        data_req = 1; data_wr = 0; data_addr = 32'h0000_0300;
        cyc();
        data_req = 0; mem_addr_ok = 1;
        cyc();
        mem_addr_ok = 0; inst_req = 1; inst_addr = 32'h0000_0400;
        #1;
        checks++;
        if ({dbg_state, inst_addr_ok} !== {S_WAIT, 1'b0})
            $display("FAIL iw_wait got state=%0d inst_addr_ok=%b exp 2 0", dbg_state, inst_addr_ok);
        else passed++;
        cyc();
        mem_data_ok = 1; mem_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({data_data_ok, inst_data_ok, inst_addr_ok, data_rdata} !== {3'b100, 32'hCAFE_F00D})
            $display("FAIL iw_rsp got data_ok=%b inst_ok=%b inst_addr_ok=%b rdata=%h exp 1 0 0 cafef00d",
                     data_data_ok, inst_data_ok, inst_addr_ok, data_rdata);
        else passed++;
        cyc();
        mem_data_ok = 0;
        #1;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10)
            $display("FAIL iw_grant got inst/data=%b%b exp 10", inst_addr_ok, data_addr_ok);
        else passed++;
        cyc();
        inst_req = 0; mem_addr_ok = 1;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0400})
            $display("FAIL iw_mem got req=%b addr=%h exp 1 00000400", mem_req, mem_addr);
        else passed++;
        cyc();
        mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10)
            $display("FAIL iw_inst_rsp got inst/data=%b%b exp 10", inst_data_ok, data_data_ok);
        else passed++;
        cyc();
        mem_data_ok = 0;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_single_inst();
        test_tie();
        test_write_stall();
        test_spurious();
        test_reset_in_wait();
        test_inst_during_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
